// File: rtl/ad9122_pkg.sv
// Shared definitions for the AD9122 SPI register-access arbiter.
package ad9122_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int RW_BIT = 7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_WAIT = 3'b010,
    ST_DONE = 3'b100
  } state_t;
endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin selector: first valid requester at or after ptr, wrapping.
module spi_rr_pick #(
  parameter int N_REQ = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);
  int unsigned      w_j;
  logic [N_REQ-1:0] w_bit;
  logic             w_found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_j       = 0;
    w_bit     = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      w_j = 32'(ptr) + off;
      if (w_j >= N_REQ) w_j = w_j - N_REQ;
      w_bit = N_REQ'(1) << w_j;
      if (!w_found && |(req_valid & w_bit)) begin
        w_found   = 1'b1;
        grant     = w_bit;
        grant_idx = IDX_W'(w_j);
      end
    end
  end
endmodule

// File: rtl/ad9122_spi_arbiter.sv
// Round-robin arbiter sharing one AD9122 SPI register engine, with a WAIT-state watchdog.
module ad9122_spi_arbiter
  import ad9122_pkg::*;
#(
  parameter int          N_REQ   = 3,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_rw,
  input  logic [ADDR_W*N_REQ-1:0] req_addr,
  input  logic [DATA_W*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]        req_ack,
  output logic [N_REQ-1:0]        req_done,
  output logic [N_REQ-1:0]        req_err,
  output logic [7:0]              req_rdata,
  output logic                    busy,
  output logic [7:0]              ad_rw_addr,
  output logic [7:0]              w_ad_data,
  output logic                    write_req,
  output logic                    read_req,
  input  logic                    r_w_end,
  input  logic [7:0]              r_ad_data
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t             r_state, w_next;
  logic [IDX_W-1:0]   r_ptr, r_gnt_idx;
  logic [N_REQ-1:0]   r_gnt_oh;
  logic [15:0]        r_wd;
  logic [N_REQ-1:0]   w_pick_grant;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_sel_rw;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_issue, w_end_ok, w_tmo;

  spi_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req_valid (req_valid),
    .ptr       (r_ptr),
    .grant     (w_pick_grant),
    .grant_idx (w_pick_idx)
  );

  assign w_sel_rw   = |(req_rw & w_pick_grant);
  assign w_sel_addr = ADDR_W'(req_addr >> (w_pick_idx * ADDR_W));
  assign w_sel_data = DATA_W'(req_wdata >> (w_pick_idx * DATA_W));
  assign busy       = (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // r_w_end takes priority over an expiring watchdog in the same cycle.
  always_comb begin
    w_next   = r_state;
    w_issue  = 1'b0;
    w_end_ok = 1'b0;
    w_tmo    = 1'b0;
    case (r_state)
      ST_IDLE: if (|req_valid) begin
        w_issue = 1'b1;
        w_next  = ST_WAIT;
      end
      ST_WAIT: if (r_w_end) begin
        w_end_ok = 1'b1;
        w_next   = ST_DONE;
      end else if (r_wd == TIMEOUT - 16'd1) begin
        w_tmo  = 1'b1;
        w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // done/err are loaded on the WAIT exit edge so the pulses occupy the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ack    <= '0;
      req_done   <= '0;
      req_err    <= '0;
      req_rdata  <= '0;
      ad_rw_addr <= '0;
      w_ad_data  <= '0;
      write_req  <= 1'b0;
      read_req   <= 1'b0;
      r_ptr      <= '0;
      r_gnt_idx  <= '0;
      r_gnt_oh   <= '0;
      r_wd       <= '0;
    end else begin
      req_ack   <= '0;
      req_done  <= '0;
      req_err   <= '0;
      write_req <= 1'b0;
      read_req  <= 1'b0;
      if (w_issue) begin
        ad_rw_addr <= {w_sel_rw, w_sel_addr};
        w_ad_data  <= w_sel_rw ? '0 : w_sel_data;
        write_req  <= !w_sel_rw;
        read_req   <= w_sel_rw;
        req_ack    <= w_pick_grant;
        r_gnt_oh   <= w_pick_grant;
        r_gnt_idx  <= w_pick_idx;
        r_wd       <= '0;
      end
      if (r_state == ST_WAIT && !w_end_ok && !w_tmo) r_wd <= r_wd + 16'd1;
      if (w_end_ok) begin
        req_rdata <= ad_rw_addr[RW_BIT] ? r_ad_data : '0;
        req_done  <= r_gnt_oh;
      end
      if (w_tmo) begin
        req_rdata <= '0;
        req_done  <= r_gnt_oh;
        req_err   <= r_gnt_oh;
      end
      if (r_state == ST_DONE)
        r_ptr <= (r_gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : r_gnt_idx + IDX_W'(1);
    end
  end
endmodule

// File: doc/ad9122_spi_arbiter.md
# ad9122_spi_arbiter

Shares the single AD9122 SPI register-access engine between several requesters: the boot register sequencer, the runtime NCO/FTW updater and the status poller. It runs one transaction at a time and grants requesters in round-robin order. It drives the engine's address/data/request inputs and returns read data and completion to the winning requester. A watchdog releases the engine if `r_w_end` never arrives.

## Interface
- `N_REQ`, 3: number of requesters (2–8).
- `TIMEOUT`, 16'd50000: cycles in WAIT before abort (≥2).
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  N_REQ  per-requester request, level; held until `req_ack`.
- `req_rw`  in  N_REQ  1 = read, 0 = write.
- `req_addr`  in  7·N_REQ  register address, requester i at [7i+6:7i].
- `req_wdata`  in  8·N_REQ  write data, requester i at [8i+7:8i].
- `req_ack`  out  N_REQ  one-cycle pulse: request latched; requester may change fields.
- `req_done`  out  N_REQ  one-cycle completion pulse.
- `req_err`  out  N_REQ  one-cycle pulse with `req_done` on timeout.
- `req_rdata`  out  8  read data, valid in the `req_done` cycle.
- `busy`  out  1  high outside IDLE.
- `ad_rw_addr`  out  8  {R/W bit, addr[6:0]} to engine; R/W=1 for read.
- `w_ad_data`  out  8  write data to engine; 0 for reads.
- `write_req` / `read_req`  out  1 each  one-cycle start pulses to engine.
- `r_w_end`  in  1  engine completion pulse.
- `r_ad_data`  in  8  engine read data, valid with `r_w_end`.

## Operation
- One-hot FSM: IDLE → WAIT → DONE → IDLE.
- IDLE: if any `req_valid`, choose winner g = first set bit at or after pointer `ptr`, wrapping. On the same edge:
  - latch `ad_rw_addr = {req_rw[g], req_addr[g]}` and `w_ad_data` (0 if read);
  - pulse `write_req` or `read_req` (exactly one) and `req_ack[g]`;
  - store g; go to WAIT.
- WAIT: the watchdog counts from 0.
  - On `r_w_end`: latch `req_rdata = r_ad_data` for a read, 0 for a write; go to DONE.
  - When count reaches TIMEOUT−1 without `r_w_end`: set `req_rdata = 0`, set error flag, go to DONE.
  - `r_w_end` and timeout in the same cycle: `r_w_end` wins, no error.
- DONE: pulse `req_done[g]` (and `req_err[g]` if the error flag is set); `ptr = (g+1) mod N_REQ`; clear the error flag; return to IDLE.
- `r_w_end` outside WAIT is ignored.
- If `req_valid` drops before being granted, nothing is issued.
- `ad_rw_addr`/`w_ad_data` hold their values until the next grant.

## Timing
- All outputs, `ptr`, the watchdog and the state reset to 0 / IDLE asynchronously on `rst`.
- After `rst` deasserts, requests are evaluated from the first rising edge.
- `req_valid` sampled at edge k → `ack`, engine request pulse and `busy` are high in cycle k+1. Address and data are stable from k+1 onward.
- `r_w_end` at edge m → `req_done` is high in cycle m+1. IDLE is entered at m+2; the next grant is at edge m+2 at the earliest.
- Reset in the middle of a transaction drops everything immediately and issues no `done`. The engine shares `rst` and aborts with it.

## Structure
- Shared package `ad9122_pkg`:
  - state localparams (IDLE/WAIT/DONE, one-hot);
  - R/W bit index 7;
  - `ADDR_W = 7`, `DATA_W = 8`.
- Sub-module `spi_rr_pick`: combinational round-robin selector. Inputs `req_valid` and `ptr`; outputs a one-hot grant and its index.
- Watchdog counter: 16 bits.

## Test plan
- Requester 1 writes 0x18←0x02; engine `r_w_end` 20 cycles after `write_req` → `ad_rw_addr` = 0x18, `w_ad_data` = 0x02, `write_req` and `ack[1]` one cycle after `valid`, `done[1]` one cycle after `r_w_end`, `err` = 0.
- Requester 0 reads 0x1F; engine returns 0x5A → `ad_rw_addr` = 0x9F, `w_ad_data` = 0, one `read_req` pulse, `req_rdata` = 0x5A in the `done[0]` cycle.
- Requesters 0, 1 and 2 held valid continuously from reset → grant order 0, 1, 2, 0, 1, 2; never two `req` pulses in one transaction.
- `TIMEOUT` = 64, engine silent → `done[g]` and `err[g]` 64 cycles after WAIT entry, `rdata` = 0, pointer advances, next request serviced normally.
- `rst` pulsed in WAIT, then `r_w_end` → all outputs 0 immediately, no `done` after release, IDLE.
- Stray `r_w_end` in IDLE; `valid` raised then dropped while another requester is being serviced → no response, no `ack`, no transaction.
